spi_host_master: RTL

- SPI master that drives the team's SPI memory slave: generates SCLK, MOSI and chip select from a simple start/busy/done request interface, and captures MISO read data.
- Sits directly upstream of the slave on the same board-level clock; one request = one complete framed transaction: address plus R/W, then one data byte.
- SCLK is generated slowly enough for the slave's input conditioners to resolve every edge.

---
 rtl/spi_host_master.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_host_master.sv
// spi_host_master: mode-0 SPI master for the SPI memory slave.
// Each request sends one 16-bit frame: {addr, rw} and then one data byte,
// written from wdata or read from miso into rdata.
// SCLK half-period is CLK_DIV clk cycles (4..255). ADDR_W+1 must equal 8.
// Optional macro SPI_HOST_MISO_SYNC_EN: miso passes through a 2-flop
// synchronizer and each read bit is captured in the 2nd cycle of the
// following low phase. Without it, miso is sampled raw on the last cycle
// of each high phase. Both sample the same miso instant; frame timing is
// the same in both builds.
module spi_host_master #(
  parameter int CLK_DIV = 8,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5,
    GAP   = 3'd6
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_reg;
  logic [7:0]  div_reg;
  logic [3:0]  bit_reg;
  logic        hold2_reg;
  logic [15:0] sh_reg;
  logic        rw_reg;
  logic [7:0]  cap_reg;
  logic        cs_reg;
  logic        sclk_reg;
  logic        mosi_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [7:0]  rdata_reg;
  logic        div_end;

  assign div_end = (div_reg == DIV_LAST);

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign rdata = rdata_reg;
  assign cs    = cs_reg;
  assign sclk  = sclk_reg;
  assign mosi  = mosi_reg;

  // Frame sequencer: every output is registered and set on the state transition.
  // HOLD is two divider periods: the trailing low half of bit 0, then
  // chip-select hold time before cs is released.
  // DONE is divider count 0 of the inter-frame gap, so DONE plus GAP spans CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      div_reg   <= 8'd0;
      bit_reg   <= 4'd0;
      hold2_reg <= 1'b0;
      sh_reg    <= 16'd0;
      rw_reg    <= 1'b0;
      cs_reg    <= 1'b1;
      sclk_reg  <= 1'b0;
      mosi_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rdata_reg <= 8'd0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sh_reg    <= {addr, rw, (rw ? 8'h00 : wdata)};
            rw_reg    <= rw;
            mosi_reg  <= addr[ADDR_W-1];
            cs_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            div_reg   <= 8'd0;
            bit_reg   <= 4'd15;
            hold2_reg <= 1'b0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (div_end) begin
            div_reg   <= 8'd0;
            sclk_reg  <= 1'b1;
            state_reg <= HIGH;
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        HIGH: begin
          if (div_end) begin
            div_reg  <= 8'd0;
            sclk_reg <= 1'b0;
            if (bit_reg == 4'd0) begin
              state_reg <= HOLD;
            end else begin
              bit_reg   <= bit_reg - 4'd1;
              mosi_reg  <= sh_reg[14];
              sh_reg    <= {sh_reg[14:0], 1'b0};
              state_reg <= LOW;
            end
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        LOW: begin
          if (div_end) begin
            div_reg   <= 8'd0;
            sclk_reg  <= 1'b1;
            state_reg <= HIGH;
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        HOLD: begin
          if (div_end) begin
            div_reg <= 8'd0;
            if (!hold2_reg) begin
              hold2_reg <= 1'b1;
            end else begin
              hold2_reg <= 1'b0;
              cs_reg    <= 1'b1;
              mosi_reg  <= 1'b0;
              done_reg  <= 1'b1;
              if (rw_reg) begin
                rdata_reg <= cap_reg;
              end
              state_reg <= DONE;
            end
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        DONE: begin
          div_reg   <= 8'd1;
          state_reg <= GAP;
        end
        GAP: begin
          if (div_end) begin
            div_reg   <= 8'd0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            div_reg <= div_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cs_reg    <= 1'b1;
          sclk_reg  <= 1'b0;
          mosi_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_HOST_MISO_SYNC_EN
  logic [1:0] miso_sync_reg;
  logic       cap_pend_reg;

  // Two-flop synchronizer on the incoming serial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync_reg <= 2'b00;
    end else begin
      miso_sync_reg <= {miso_sync_reg[0], miso};
    end
  end

  // Flag a read bit at the end of high, then shift it in on the 2nd low cycle.
  // The synchronizer delay makes that the same miso instant as a raw
  // sample on the last high cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg      <= 8'd0;
      cap_pend_reg <= 1'b0;
    end else if (state_reg == HIGH && div_end && rw_reg && bit_reg <= 4'd7) begin
      cap_pend_reg <= 1'b1;
    end else if ((state_reg == LOW || state_reg == HOLD) && div_reg == 8'd1 && cap_pend_reg) begin
      cap_reg      <= {cap_reg[6:0], miso_sync_reg[1]};
      cap_pend_reg <= 1'b0;
    end
  end
`else
  // Sample miso raw on the last cycle of each high phase of the data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg <= 8'd0;
    end else if (state_reg == HIGH && div_end && rw_reg && bit_reg <= 4'd7) begin
      cap_reg <= {cap_reg[6:0], miso};
    end
  end
`endif

endmodule
